// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_arbiter
//  Brief    : Registered REQ_N-way arbiter with a valid/ready grant output.
//             Run-time selectable fixed-priority (highest index wins) or
//             round-robin mode. Optional burst lock enabled by defining the
//             macro ARB_LOCK_EN, which adds the i_lock port.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter #(
    parameter int REQ_N = 12,
    parameter int OUT_N = $clog2(REQ_N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REQ_N-1:0] i_req,
    input  logic             i_mode,
    input  logic             i_ready,
`ifdef ARB_LOCK_EN
    input  logic             i_lock,
`endif
    output logic             o_valid,
    output logic [OUT_N-1:0] o_data,
    output logic [REQ_N-1:0] o_grant
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic             r_valid;
    logic [OUT_N-1:0] r_data;
    logic [OUT_N-1:0] r_rr_ptr;

    logic             w_lock;
    logic             w_any;
    logic             w_accept;
    logic             w_withdraw;
    logic             w_burst;
    logic [OUT_N-1:0] w_next_ptr;
    logic [OUT_N-1:0] w_arb_ptr;
    logic [OUT_N:0]   w_sum;
    logic             w_rr_found;
    logic [OUT_N-1:0] w_rr_idx;
    logic [OUT_N-1:0] w_fix_idx;
    logic [OUT_N-1:0] w_winner;
    logic [REQ_N-1:0] w_grant;

`ifdef ARB_LOCK_EN
    assign w_lock = i_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_any      = |i_req;
    assign w_accept   = r_valid & i_ready;
    // The held winner dropping its request revokes the grant; it is never an accept.
    assign w_withdraw = r_valid & ~i_ready & ~i_req[r_data];
    // Burst lock keeps the same index as long as it is still requesting.
    assign w_burst    = w_accept & w_lock & i_req[r_data];
    assign w_next_ptr = (r_data == OUT_N'(REQ_N - 1)) ? '0 : r_data + OUT_N'(1);
    // Re-arbitration on an accept edge already sees the advanced pointer.
    assign w_arb_ptr  = (w_accept & i_mode & ~w_burst) ? w_next_ptr : r_rr_ptr;

    // Fixed priority: the last set bit found scanning upward is the highest index.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (i_req[i]) begin
                w_fix_idx = OUT_N'(i);
            end
        end
    end

    // Round-robin: first set bit scanning upward from the pointer, modulo REQ_N.
    always_comb begin
        w_sum      = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < REQ_N; i++) begin
            w_sum = {1'b0, w_arb_ptr} + (OUT_N+1)'(i);
            if (w_sum >= (OUT_N+1)'(REQ_N)) begin
                w_sum = w_sum - (OUT_N+1)'(REQ_N);
            end
            if (!w_rr_found && i_req[w_sum[OUT_N-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_sum[OUT_N-1:0];
            end
        end
    end

    assign w_winner = i_mode ? w_rr_idx : w_fix_idx;

    // State, grant and pointer registers; reset dominates everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= c_IDLE;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state <= c_GRANT;
                        r_valid <= 1'b1;
                        r_data  <= w_winner;
                    end
                end
                c_GRANT: begin
                    if (w_accept) begin
                        if (i_mode && !w_burst) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                        if (w_burst) begin
                            r_data <= r_data;
                        end else if (w_any) begin
                            r_data <= w_winner;
                        end else begin
                            r_state <= c_IDLE;
                            r_valid <= 1'b0;
                        end
                    end else if (w_withdraw) begin
                        if (w_any) begin
                            r_data <= w_winner;
                        end else begin
                            r_state <= c_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // One-hot grant decoded from registered state only.
    always_comb begin
        w_grant = '0;
        if (r_valid) begin
            w_grant[r_data] = 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_priority_arbiter
//  Brief    : Scoreboard bench for rr_priority_arbiter (REQ_N = 12): directed
//             scenarios followed by random traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_priority_arbiter;

    localparam int c_N = 12;

    logic           r_clk = 1'b0;
    logic           r_rst_n = 1'b0;
    logic [c_N-1:0] r_req = '0;
    logic           r_mode = 1'b0;
    logic           r_ready = 1'b0;
    logic           r_lock = 1'b0;
    logic           w_valid;
    logic [3:0]     w_data;
    logic [c_N-1:0] w_grant;

    int total = 0;
    int bad   = 0;

    // Expected outputs after each clock edge, in edge order.
    int q_v[$];
    int q_d[$];

    // Reference model state.
    int m_valid = 0;
    int m_data  = 0;
    int m_ptr   = 0;

    rr_priority_arbiter #(.REQ_N(c_N)) dut (
        .i_clk   (r_clk),
        .i_rst_n (r_rst_n),
        .i_req   (r_req),
        .i_mode  (r_mode),
        .i_ready (r_ready),
`ifdef ARB_LOCK_EN
        .i_lock  (r_lock),
`endif
        .o_valid (w_valid),
        .o_data  (w_data),
        .o_grant (w_grant)
    );

    always #5 r_clk = ~r_clk;

    function automatic int pick(input logic [c_N-1:0] req, input logic mode, input int ptr);
        if (!mode) begin
            for (int k = c_N - 1; k >= 0; k--) if (req[k]) return k;
        end else begin
            for (int k = 0; k < c_N; k++) if (req[(ptr + k) % c_N]) return (ptr + k) % c_N;
        end
        return 0;
    endfunction

    // Apply one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input logic rst_n, input logic [c_N-1:0] req, input logic mode,
                        input logic ready, input logic lock);
        logic lk;
        @(negedge r_clk);
        #1;
        r_rst_n = rst_n; r_req = req; r_mode = mode; r_ready = ready; r_lock = lock;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_ptr = 0;
        end else if (m_valid == 0) begin
            if (req != 0) begin m_valid = 1; m_data = pick(req, mode, m_ptr); end
        end else if (ready) begin
            if (lk && req[m_data]) begin
                // same index re-granted, pointer frozen
            end else begin
                if (mode) m_ptr = (m_data + 1) % c_N;
                if (req != 0) m_data = pick(req, mode, m_ptr);
                else m_valid = 0;
            end
        end else if (!req[m_data]) begin
            if (req != 0) m_data = pick(req, mode, m_ptr);
            else m_valid = 0;
        end
        q_v.push_back(m_valid);
        q_d.push_back(m_data);
    endtask

    // Direct check of the current outputs (the result of the previous step's edge).
    task automatic dchk(input string name, input int ev, input int ed);
        total++;
        if (int'(w_valid) != ev || (ev != 0 && int'(w_data) != ed)) begin
            bad++;
            $display("FAIL %s: got valid=%0d data=%0d, want valid=%0d data=%0d",
                     name, w_valid, w_data, ev, ed);
        end
    endtask

    // Monitor: every edge's outputs are compared against the scoreboard.
    initial begin
        int ev, ed;
        logic [c_N-1:0] eg;
        forever begin
            @(negedge r_clk);
            if (q_v.size() > 0) begin
                ev = q_v.pop_front();
                ed = q_d.pop_front();
                eg = '0;
                if (ev != 0) eg[ed] = 1'b1;
                total++;
                if (int'(w_valid) != ev || int'(w_data) != ed || w_grant != eg) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got v=%0d d=%0d g=%03h, want v=%0d d=%0d g=%03h",
                             $time, w_valid, w_data, w_grant, ev, ed, eg);
                end
            end
        end
    end

    initial begin
        // Reset with all requests asserted.
        step(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0);
        dchk("reset_idle", 0, 0);
        step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
        dchk("reset_held", 0, 0);
        step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
        dchk("release_latency", 1, 11);

        // Fixed priority.
        step(1'b1, 12'h0A4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 12'h0A4, 1'b0, 1'b1, 1'b0);
        dchk("fixed_prio", 1, 7);

        // Round-robin from reset, wrap 11 -> 0.
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0); dchk("rr_seq0", 1, 0);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0); dchk("rr_seq1", 1, 4);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0); dchk("rr_seq2", 1, 11);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0); dchk("rr_wrap", 1, 0);
        step(1'b1, 12'h811, 1'b1, 1'b1, 1'b0); dchk("rr_seq4", 1, 4);

        // Backpressure holds grant 3 while bit 9 rises.
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h008, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'h208, 1'b1, 1'b0, 1'b0);
        dchk("backpressure_hold", 1, 3);
        step(1'b1, 12'h208, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h208, 1'b1, 1'b0, 1'b0);
        dchk("after_accept", 1, 9);

        // Withdrawal to a remaining request, then to nothing.
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h020, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h004, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h004, 1'b1, 1'b0, 1'b0);
        dchk("withdraw_regrant", 1, 2);
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h020, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
        dchk("withdraw_idle", 0, 0);

`ifdef ARB_LOCK_EN
        // Burst lock.
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h003, 1'b1, 1'b1, 1'b1);
        step(1'b1, 12'h003, 1'b1, 1'b1, 1'b1); dchk("lock0", 1, 0);
        step(1'b1, 12'h003, 1'b1, 1'b1, 1'b1); dchk("lock1", 1, 0);
        step(1'b1, 12'h003, 1'b1, 1'b1, 1'b0); dchk("lock2", 1, 0);
        step(1'b1, 12'h003, 1'b1, 1'b0, 1'b0); dchk("unlock", 1, 1);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [c_N-1:0] rq;
            rq = c_N'($urandom);
            if ($urandom_range(0, 2) == 0) rq = rq & c_N'($urandom);
            if ($urandom_range(0, 7) == 0) rq = '0;
            step(($urandom_range(0, 49) != 0), rq, 1'($urandom), 1'($urandom),
                 1'($urandom));
        end

        repeat (2) @(negedge r_clk);
        #2;
        total++;
        if (q_v.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q_v.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
